wb_gpio: RTL
============

WB_GPIO -- requirements
Module: wb_gpio

Parameters
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of GPIO pins (1..32); all register fields SHALL use bits [WIDTH-1:0], and unused upper bits SHALL read 0.

Interface
REQ-002 The block SHALL have port CLK_I, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RST_I, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have ports CYC_I and STB_I, input, 1 bit each: Wishbone cycle and strobe.
REQ-005 The block SHALL have port WE_I, input, 1 bit: Wishbone write enable.
REQ-006 The block SHALL have port ADR_I, input, 3 bits: word select for the register map (REQ-010).
REQ-007 The block SHALL have ports DAT_I (input, 32 bits, write data), SEL_I (input, 4 bits, byte enables; only SEL_I[0] is honoured, and it gates writes of bits [7:0]), DAT_O (output, 32 bits, read data) and ACK_O (output, 1 bit, transfer acknowledge).
REQ-008 The block SHALL have ports GPIO_I (input, WIDTH, pad input), GPIO_O (output, WIDTH, pad output value), GPIO_OE (output, WIDTH, pad output enable; 1 = driven) and IRQ_O (output, 1 bit, level interrupt).
REQ-009 The block SHALL have ports IN_O, OUT_O and DIR_O, outputs, WIDTH each: the current synchronised input, output and direction registers, provided for simulation monitors.

Function
REQ-010 Register map, selected by ADR_I:
- 0 IN: read-only.
- 1 OUT: read/write.
- 2 DIR: read/write.
- 3 IRQ_EN: read/write.
- 4 IRQ_EDGE: read/write; 1 = rising, 0 = falling.
- 5 IRQ_STAT: read; write-1-to-clear.
- 6 OUT_SET: write-only; OUT |= DAT_I.
- 7 OUT_CLR: write-only; OUT &= ~DAT_I.
Reads of addresses 6 and 7 SHALL return 0.
REQ-011 A transfer starts when CYC_I & STB_I & !ACK_O at a clock edge. ACK_O SHALL be 1 for exactly the following cycle and 0 in the cycle after, so every transfer takes 2 cycles and there are no back-to-back ACKs.
REQ-012 Write side effects and DAT_O SHALL be registered on the same edge that raises ACK_O. DAT_O SHALL hold its value until the next transfer.
REQ-013 Writes with SEL_I[0]=0 SHALL be acknowledged without modifying any register.
REQ-014 GPIO_I SHALL pass through a 2-flop synchroniser (s1, then s2). IN SHALL equal s2, so a pad change is readable after 2 edges. A third flop s3 SHALL hold the previous s2 value.
REQ-015 A pin event SHALL be: for IRQ_EDGE=1, s2 & ~s3; for IRQ_EDGE=0, ~s2 & s3.
REQ-016 On the edge after an event on a pin whose IRQ_EN bit is 1, that pin's IRQ_STAT bit SHALL be set. IRQ_O SHALL be the combinational OR of the IRQ_STAT bits, so IRQ_O rises 3 edges after the pad change.
REQ-017 If an event and a W1C of the same IRQ_STAT bit occur on the same edge, the bit SHALL end up set (set wins).
REQ-018 Clearing an IRQ_EN bit SHALL NOT clear the corresponding IRQ_STAT bit.
REQ-019 GPIO_O SHALL equal OUT and GPIO_OE SHALL equal DIR. IN SHALL reflect the pad regardless of DIR.
REQ-020 If OUT_SET and OUT_CLR name the same bit in separate transfers, the later transfer SHALL win. OUT SHALL change only on the ACK edge.

Reset
REQ-021 While RST_I is high at an edge, the following SHALL be cleared to 0: OUT, DIR, IRQ_EN, IRQ_EDGE, IRQ_STAT, s1, s2, s3, ACK_O and DAT_O. Consequently GPIO_OE=0, GPIO_O=0 and IRQ_O=0.
REQ-022 Reset SHALL take priority over everything else. A transfer pending at the reset edge SHALL be dropped with no ACK and no register update. Following reset release, the first transfer SHALL be accepted on the first qualifying edge.

Verification
REQ-023 Write OUT=8'hA5 and DIR=8'h0F, then read both -> each ACK_O is 1 for one cycle, 2 cycles after STB; reads return 32'h000000A5 and 32'h0000000F; GPIO_O=A5 and GPIO_OE=0F.
REQ-024 With OUT=A5: write OUT_SET=8'h02, then OUT_CLR=8'h81 -> OUT reads 8'h26; reads of addresses 6 and 7 return 0.
REQ-025 Set IRQ_EN=8'h01 and IRQ_EDGE=8'h01, drive GPIO_I[0] 0->1 -> IN[0]=1 after 2 edges; IRQ_O=1 after 3 edges; IRQ_STAT reads 8'h01. Driving GPIO_I[1] 0->1 (not enabled) SHALL NOT set IRQ_STAT[1].
REQ-026 With IRQ_STAT[0]=1, make a W1C write of 8'h01 on the same edge as a new rising event on pin 0 -> IRQ_STAT[0] remains 1 and IRQ_O stays 1. A W1C with no concurrent event -> IRQ_O=0.
REQ-027 Assert RST_I while STB_I is high with write OUT=8'hFF pending -> no ACK_O; OUT=0; all outputs 0. After release, the same write is acknowledged 2 cycles after STB and OUT=FF.
REQ-028 Write OUT=8'h3C with SEL_I=4'b1110 -> ACK_O pulses once; OUT is unchanged.

Source files
------------

// File: rtl/wb_gpio.sv
// Wishbone-attached GPIO block with per-pin direction, atomic set/clear and edge interrupts.
// Latency: each transfer is acknowledged one cycle after it is accepted, and every transfer takes two cycles.
// Backpressure: none; a transfer is accepted whenever CYC_I & STB_I are high and ACK_O is low.
//
// Ports:
//   CLK_I, RST_I            - clock, synchronous active-high reset
//   CYC_I, STB_I, WE_I      - Wishbone cycle, strobe and write enable
//   ADR_I[2:0]              - register word select
//   DAT_I, SEL_I            - write data and byte enables (SEL_I[0] gates the whole write)
//   DAT_O, ACK_O            - registered read data and transfer acknowledge
//   GPIO_I/GPIO_O/GPIO_OE   - pad input, pad output value, pad output enable
//   IRQ_O                   - level interrupt, OR of the pending-status bits
//   IN_O, OUT_O, DIR_O      - monitor copies of the input, output and direction registers
module wb_gpio #(
  parameter int WIDTH = 8
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic             CYC_I,
  input  logic             STB_I,
  input  logic             WE_I,
  input  logic [2:0]       ADR_I,
  input  logic [31:0]      DAT_I,
  input  logic [3:0]       SEL_I,
  output logic [31:0]      DAT_O,
  output logic             ACK_O,
  input  logic [WIDTH-1:0] GPIO_I,
  output logic [WIDTH-1:0] GPIO_O,
  output logic [WIDTH-1:0] GPIO_OE,
  output logic             IRQ_O,
  output logic [WIDTH-1:0] IN_O,
  output logic [WIDTH-1:0] OUT_O,
  output logic [WIDTH-1:0] DIR_O
);

  localparam logic [2:0] A_IN       = 3'd0;
  localparam logic [2:0] A_OUT      = 3'd1;
  localparam logic [2:0] A_DIR      = 3'd2;
  localparam logic [2:0] A_IRQ_EN   = 3'd3;
  localparam logic [2:0] A_IRQ_EDGE = 3'd4;
  localparam logic [2:0] A_IRQ_STAT = 3'd5;
  localparam logic [2:0] A_OUT_SET  = 3'd6;
  localparam logic [2:0] A_OUT_CLR  = 3'd7;

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] ien_q, ien_d;
  logic [WIDTH-1:0] iedge_q, iedge_d;
  logic [WIDTH-1:0] istat_q, istat_d;
  logic [WIDTH-1:0] s1_q, s2_q, s3_q;
  logic             ack_q, ack_d;
  logic [31:0]      dat_q, dat_d;

  logic             xfer;
  logic             wr;
  logic [WIDTH-1:0] wdat;
  logic [WIDTH-1:0] evt;

  // Upper data bits and upper byte enables have no effect on this block.
  logic unused_bits;
  assign unused_bits = ^{DAT_I, SEL_I[3:1]};

  // The ~ack_q term forces an idle cycle between acknowledges.
  assign xfer = CYC_I & STB_I & ~ack_q;
  assign wr   = xfer & WE_I & SEL_I[0];
  assign wdat = DAT_I[WIDTH-1:0];

  // s3 holds the previous synchronised value, so events are one-cycle pulses.
  assign evt = (iedge_q & s2_q & ~s3_q) | (~iedge_q & ~s2_q & s3_q);

  always_comb begin
    out_d   = out_q;
    dir_d   = dir_q;
    ien_d   = ien_q;
    iedge_d = iedge_q;
    istat_d = istat_q;
    dat_d   = dat_q;
    ack_d   = xfer;

    if (wr) begin
      case (ADR_I)
        A_OUT:      out_d   = wdat;
        A_DIR:      dir_d   = wdat;
        A_IRQ_EN:   ien_d   = wdat;
        A_IRQ_EDGE: iedge_d = wdat;
        A_IRQ_STAT: istat_d = istat_q & ~wdat;
        A_OUT_SET:  out_d   = out_q | wdat;
        A_OUT_CLR:  out_d   = out_q & ~wdat;
        default: ;
      endcase
    end

    // Applied after the W1C so a coincident event keeps its status bit set.
    istat_d = istat_d | (evt & ien_q);

    if (xfer) begin
      dat_d = '0;
      case (ADR_I)
        A_IN:       dat_d[WIDTH-1:0] = s2_q;
        A_OUT:      dat_d[WIDTH-1:0] = out_q;
        A_DIR:      dat_d[WIDTH-1:0] = dir_q;
        A_IRQ_EN:   dat_d[WIDTH-1:0] = ien_q;
        A_IRQ_EDGE: dat_d[WIDTH-1:0] = iedge_q;
        A_IRQ_STAT: dat_d[WIDTH-1:0] = istat_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      out_q   <= '0;
      dir_q   <= '0;
      ien_q   <= '0;
      iedge_q <= '0;
      istat_q <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      out_q   <= out_d;
      dir_q   <= dir_d;
      ien_q   <= ien_d;
      iedge_q <= iedge_d;
      istat_q <= istat_d;
      s1_q    <= GPIO_I;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
    end
  end

  assign DAT_O   = dat_q;
  assign ACK_O   = ack_q;
  assign GPIO_O  = out_q;
  assign GPIO_OE = dir_q;
  assign IRQ_O   = |istat_q;
  assign IN_O    = s2_q;
  assign OUT_O   = out_q;
  assign DIR_O   = dir_q;

endmodule
